// File: rtl/strange_pkg.sv
// rtl/strange_pkg.sv - shared types and helpers for the strange_panel display front end
package strange_pkg;

  typedef enum logic [1:0] {
    LIVE = 2'd0,
    HIST = 2'd1,
    SUM  = 2'd2
  } mode_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Value is one plus the index of the highest set switch, zero when none are set.
  function automatic logic [3:0] encode_choice(input logic [14:0] bits);
    logic [3:0] v;
    v = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (bits[i]) v = 4'(i + 1);
    end
    return v;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchroniser, debounce and rising-edge pulse for one raw button
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Counter tracks consecutive samples disagreeing with the accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/strange_panel.sv
// rtl/strange_panel.sv - debounced digit entry with history, rotate/clear/sum modes and multiplexed display
module strange_panel
  import strange_pkg::*;
#(
  parameter int DIGIT_NUM       = 7,
  parameter int HISTORY_DEPTH   = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_CYCLES     = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIGIT_NUM-1:0]     digit_choice,
  input  logic                     digit_load,
  input  logic                     digit_change,
  input  logic                     mode_change,
  output logic [6:0]               display,
  output logic [HISTORY_DEPTH-1:0] an,
  output logic                     digit_load_indicator
);

  localparam int CNT_W  = $clog2(HISTORY_DEPTH + 1);
  localparam int IDX_W  = $clog2(HISTORY_DEPTH);
  localparam int SUM_W  = $clog2(HISTORY_DEPTH * 15 + 1);
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(HISTORY_DEPTH);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(HISTORY_DEPTH - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic load_pulse;
  logic change_pulse;
  logic mode_pulse;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk  (clk),
    .rst  (rst),
    .raw  (digit_load),
    .pulse(load_pulse)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_change (
    .clk  (clk),
    .rst  (rst),
    .raw  (digit_change),
    .pulse(change_pulse)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk  (clk),
    .rst  (rst),
    .raw  (mode_change),
    .pulse(mode_pulse)
  );

  logic [DIGIT_NUM-1:0] choice_s1;
  logic [DIGIT_NUM-1:0] choice_s2;
  logic [3:0]           value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      choice_s1 <= '0;
      choice_s2 <= '0;
    end else begin
      choice_s1 <= digit_choice;
      choice_s2 <= choice_s1;
    end
  end

  assign value = encode_choice(15'(choice_s2));

  mode_t            mode;
  logic [3:0]       hist [HISTORY_DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [3:0]       oldest;

  always_comb begin
    oldest = 4'd0;
    for (int i = 0; i < HISTORY_DEPTH; i++) begin
      if (CNT_W'(i + 1) == cnt) oldest = hist[i];
    end
  end

  // Mode beats change beats load; losers in the same cycle are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode                 <= LIVE;
      cnt                  <= '0;
      digit_load_indicator <= 1'b0;
      for (int i = 0; i < HISTORY_DEPTH; i++) hist[i] <= 4'd0;
    end else begin
      digit_load_indicator <= 1'b0;
      if (mode_pulse) begin
        case (mode)
          LIVE:    mode <= HIST;
          HIST:    mode <= SUM;
          default: mode <= LIVE;
        endcase
      end else if (change_pulse) begin
        if (mode == LIVE) begin
          cnt <= '0;
          for (int i = 0; i < HISTORY_DEPTH; i++) hist[i] <= 4'd0;
        end else if (mode == HIST && cnt > CNT_W'(1)) begin
          hist[0] <= oldest;
          for (int i = 1; i < HISTORY_DEPTH; i++) begin
            if (CNT_W'(i) < cnt) hist[i] <= hist[i-1];
          end
        end
      end else if (load_pulse) begin
        hist[0] <= value;
        for (int i = 1; i < HISTORY_DEPTH; i++) hist[i] <= hist[i-1];
        if (cnt != CNT_FULL) cnt <= cnt + 1'b1;
        digit_load_indicator <= 1'b1;
      end
    end
  end

  logic [SUM_W-1:0] sum;
  logic [7:0]       sum_ext;

  always_comb begin
    sum = '0;
    for (int i = 0; i < HISTORY_DEPTH; i++) begin
      if (CNT_W'(i) < cnt) sum = sum + SUM_W'(hist[i]);
    end
  end

  assign sum_ext = 8'(sum);

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  scan_idx;
  logic              cur_valid;
  logic [3:0]        cur_val;

  always_comb begin
    cur_valid = 1'b0;
    cur_val   = 4'd0;
    case (mode)
      LIVE: begin
        if (scan_idx == '0) begin
          cur_valid = 1'b1;
          cur_val   = value;
        end
      end
      HIST: begin
        for (int i = 0; i < HISTORY_DEPTH; i++) begin
          if (IDX_W'(i) == scan_idx && CNT_W'(i) < cnt) begin
            cur_valid = 1'b1;
            cur_val   = hist[i];
          end
        end
      end
      default: begin
        if (scan_idx == IDX_W'(0)) begin
          cur_valid = 1'b1;
          cur_val   = sum_ext[3:0];
        end else if (scan_idx == IDX_W'(1)) begin
          cur_valid = 1'b1;
          cur_val   = sum_ext[7:4];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an       <= HISTORY_DEPTH'(1);
      display  <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an      <= HISTORY_DEPTH'(1) << scan_idx;
      display <= cur_valid ? hex_to_seg(cur_val) : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_strange_panel.sv
// tb/tb_strange_panel.sv - scoreboard bench for strange_panel
module tb_strange_panel;

  localparam int DN = 7;
  localparam int HD = 4;
  localparam int DB = 4;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DN-1:0] digit_choice = '0;
  logic          digit_load = 1'b0;
  logic          digit_change = 1'b0;
  logic          mode_change = 1'b0;
  logic [6:0]    display;
  logic [HD-1:0] an;
  logic          digit_load_indicator;

  int n_checks = 0;
  int n_fail = 0;
  int ind_count = 0;

  logic [6:0]    exp_q [$];
  logic [HD-1:0] an_q [$];

  strange_panel #(
    .DIGIT_NUM(DN),
    .HISTORY_DEPTH(HD),
    .DEBOUNCE_CYCLES(DB),
    .SCAN_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digit_choice(digit_choice),
    .digit_load(digit_load),
    .digit_change(digit_change),
    .mode_change(mode_change),
    .display(display),
    .an(an),
    .digit_load_indicator(digit_load_indicator)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && digit_load_indicator) ind_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int h);
    case (h)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      14: return 7'b1111001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_disp(input int a, input int b, input int c, input int d);
    exp_q.push_back(seg(a));
    exp_q.push_back(seg(b));
    exp_q.push_back(seg(c));
    exp_q.push_back(seg(d));
  endtask

  // 0 = load, 1 = change, 2 = mode
  task automatic press(input int which, input int hold);
    case (which)
      0: digit_load = 1'b1;
      1: digit_change = 1'b1;
      default: mode_change = 1'b1;
    endcase
    cycles(hold);
    digit_load = 1'b0;
    digit_change = 1'b0;
    mode_change = 1'b0;
    cycles(12);
  endtask

  task automatic scan_check(input string tag);
    logic [6:0]    e;
    logic [HD-1:0] want;
    int w;
    cycles(3);
    for (int p = 0; p < HD; p++) begin
      want = HD'(1) << p;
      w = 0;
      while (an !== want && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) check_eq($sformatf("%s timeout pos%0d", tag, p), 32'(an), 32'(want));
      e = exp_q.pop_front();
      check_eq($sformatf("%s pos%0d", tag, p), 32'(display), 32'(e));
    end
  endtask

  initial begin
    int n;
    logic [HD-1:0] cur;
    logic [HD-1:0] prev;

    cycles(3);
    rst = 1'b1;
    #1;
    check_eq("reset an", 32'(an), 32'h1);
    check_eq("reset display", 32'(display), 32'h0);
    check_eq("reset indicator", 32'(digit_load_indicator), 32'h0);

    digit_choice = 7'b0000101;
    digit_load = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    #1;
    check_eq("midreset an", 32'(an), 32'h1);
    check_eq("midreset display", 32'(display), 32'h0);
    check_eq("midreset indicator", 32'(digit_load_indicator), 32'h0);
    digit_load = 1'b0;
    cycles(10);
    check_eq("no load after reset", ind_count, 0);
    push_disp(3, -1, -1, -1);
    scan_check("live after reset");

    press(0, 3);
    check_eq("short press ignored", ind_count, 0);
    press(0, 10);
    check_eq("long press loads", ind_count, 1);
    push_disp(3, -1, -1, -1);
    press(2, 10);
    scan_check("hist one");
    push_disp(3, 0, -1, -1);
    press(2, 10);
    scan_check("sum one");
    press(2, 10);

    press(1, 10);
    digit_choice = 7'b0000001;
    cycles(3);
    digit_load = 1'b1;
    n = 0;
    while (!digit_load_indicator && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_eq("load latency", n, DB + 4);
    digit_load = 1'b0;
    cycles(12);
    for (int v = 2; v <= 5; v++) begin
      digit_choice = DN'(1) << (v - 1);
      cycles(3);
      press(0, 10);
    end
    check_eq("load count", ind_count, 6);
    push_disp(5, 4, 3, 2);
    press(2, 10);
    scan_check("hist full");
    push_disp(2, 5, 4, 3);
    press(1, 10);
    scan_check("rotate");
    push_disp(14, 0, -1, -1);
    press(2, 10);
    scan_check("sum");
    push_disp(14, 0, -1, -1);
    press(1, 10);
    scan_check("sum change ignored");
    press(2, 10);

    digit_load = 1'b1;
    mode_change = 1'b1;
    cycles(10);
    digit_load = 1'b0;
    mode_change = 1'b0;
    cycles(12);
    check_eq("simul no load", ind_count, 6);
    push_disp(2, 5, 4, 3);
    scan_check("simul mode");
    press(2, 10);
    press(2, 10);

    press(1, 10);
    push_disp(-1, -1, -1, -1);
    press(2, 10);
    scan_check("cleared");

    an_q.push_back(4'b0010);
    an_q.push_back(4'b0100);
    an_q.push_back(4'b1000);
    an_q.push_back(4'b0001);
    n = 0;
    prev = an;
    @(negedge clk);
    while (!(an == 4'b0001 && prev == 4'b1000) && n < 40) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    if (n >= 40) check_eq("scan sync timeout", 32'(an), 32'h1);
    for (int s = 0; s < HD; s++) begin
      cur = an;
      n = 0;
      while (an == cur && n < 10) begin
        @(negedge clk);
        n++;
      end
      check_eq($sformatf("scan dwell %0d", s), n, SC);
      check_eq($sformatf("scan an %0d", s), 32'(an), 32'(an_q.pop_front()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/strange_panel.md
# strange_panel

Parametrised successor of the single-display digit device: conditions three raw push-buttons (synchroniser, debounce, rising-edge pulse), encodes a switch bank into a digit, keeps a history of loaded digits and drives a time-multiplexed bank of HISTORY_DEPTH seven-segment positions. It sits directly between board pins and the display, replacing the bare edge-detector front end with debounced inputs and adding history rotation, clear and sum modes.

## Interface
- DIGIT_NUM, 7, number of choice switches (1..15)
- HISTORY_DEPTH, 4, stored digits and display positions (2..8)
- DEBOUNCE_CYCLES, 4, stable samples required before a button level is accepted (≥1)
- SCAN_CYCLES, 1000, clock cycles each display position stays lit (≥1)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- digit_choice  in  DIGIT_NUM  raw switch bank
- digit_load / digit_change / mode_change  in  1 each  raw buttons, active-high
- display  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
- an  out  HISTORY_DEPTH  one-hot position enable, active-high, registered
- digit_load_indicator  out  1  one-cycle pulse per accepted load, registered

One clock; reset is asynchronous and active-low.

## Operation
- Button conditioning (per button): 2-flop synchroniser → counter; debounced level flips only after DEBOUNCE_CYCLES consecutive synchronised samples differing from it; counter clears on any agreeing sample; one-cycle pulse on debounced 0→1. Release produces no pulse.
- digit_choice synchronised with 2 flops; encoded value v = (index of highest set bit)+1, v = 0 when no bit set; 4 bits.
- History: shift register hist[0..HISTORY_DEPTH-1], hist[0] newest, plus count cnt (0..HISTORY_DEPTH, saturating).
- Mode FSM: LIVE → HIST → SUM → LIVE on each mode pulse; reset state LIVE.
- Load pulse: any mode; hist shifts toward higher index, hist[0]=v, oldest lost when full; cnt=min(cnt+1,HISTORY_DEPTH); indicator pulses.
- Change pulse: LIVE → clear history (cnt=0, all entries 0); HIST → rotate: hist[0] takes hist[cnt-1], entries 0..cnt-2 move up one, no-op when cnt≤1; SUM → ignored.
- Priority in the same cycle: mode > change > load; lower-priority pulses that cycle are dropped (no indicator).
- Position content: LIVE: pos 0 = v, others blank. HIST: pos i = hist[i] if i<cnt, else blank. SUM: s = sum of valid entries (width ceil(log2(HISTORY_DEPTH*15+1))), pos 0 = s[3:0], pos 1 = s[7:4], others blank.
- Scan: counter 0..SCAN_CYCLES-1; on wrap, position index increments modulo HISTORY_DEPTH.
- Hex-to-seg for 0..F, blank = 7'b0.

## Timing
- Reset: mode LIVE, cnt 0, hist all 0, debounced levels 0, scan index 0, an = 1 (position 0), display = 0, indicator 0. Reset mid-debounce or mid-scan discards all progress.
- Raw button rising at edge k (held stable) → internal pulse at edge k+DEBOUNCE_CYCLES+2, state update and indicator at edge k+DEBOUNCE_CYCLES+3.
- display/an are registered from position index and content: one-cycle latency after any state or index change; an and display always change on the same edge.
- Glitches shorter than DEBOUNCE_CYCLES samples produce no pulse.

## Structure
- Package strange_pkg: mode enum (LIVE, HIST, SUM), SEG_BLANK constant, hex_to_seg function, value-encode function.
- Sub-module button_conditioner (synchroniser + debounce + edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times; rest in strange_panel.

## Test plan
- Reset mid-operation with load held: after release, an=0001, display=0, indicator 0, mode LIVE.
- digit_choice=7'b0000101, press load 3 cycles only (DEBOUNCE_CYCLES=4) → no indicator; hold 10 cycles → exactly one indicator pulse, hist[0]=3.
- Load 1,2,3,4,5 (depth 4), HIST mode → pos0..3 show 5,4,3,2; rotate once → 2,5,4,3.
- History 5,4,3,2, SUM mode → pos0 shows E, pos1 shows 0; change pulse ignored.
- mode and load debounced on the same cycle → mode advances, no load, no indicator.
- LIVE, change pulse → cnt 0; HIST mode → all positions blank; SCAN_CYCLES=3 → an steps every 3 cycles, wraps 1000→0001.
